// File: rtl/data_sram_if.sv
// Sram-like data bus between the MEM-stage bridge (master) and the memory system (slave).
// Two-phase protocol: request accepted on data_addr_ok, completed on data_data_ok.
interface data_sram_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wstrb,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wstrb,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

// File: rtl/data_sram_bridge.sv
// Turns one MEM-stage load/store into a two-phase sram-like bus transaction, stalling the
// pipeline until it completes and draining (discarding) transactions killed by flush/exception.
module data_sram_bridge #(
    parameter bit KSEG_MAP = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_en,
    input  logic         mem_wen,
    input  logic [31:0]  mem_addr,
    input  logic [3:0]   mem_sel,
    input  logic [31:0]  mem_wdata,
    input  logic [1:0]   mem_size,
    input  logic         mem_except,
    input  logic         flush,
    input  logic         stall_others,
    data_sram_if.master  bus,
    output logic [31:0]  mem_rdata,
    output logic         mem_stall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        discard_reg;
    logic        discard_next;
    logic [31:0] rdata_buf_reg;

    logic        wr_reg;
    logic [1:0]  size_reg;
    logic [31:0] addr_reg;
    logic [3:0]  wstrb_reg;
    logic [31:0] wdata_reg;

    logic        start;
    logic        kill;
    logic        latch_req;
    logic        capture;
    logic        in_flight;
    logic        use_reg;
    logic [31:0] phys_addr;
    logic [3:0]  wstrb_out;
    logic [31:0] wdata_out;

    assign start     = mem_en & ~mem_except & ~flush;
    assign kill      = discard_reg | flush | mem_except;
    assign in_flight = (state_reg == S_ADDR) | (state_reg == S_DATA);
    assign use_reg   = (state_reg != S_IDLE);

    // kseg0/kseg1 are unmapped windows onto the low 512 MB of physical memory.
    generate
        if (KSEG_MAP) begin : g_kseg
            assign phys_addr = (mem_addr[31:30] == 2'b10) ? {3'b000, mem_addr[28:0]} : mem_addr;
        end else begin : g_pass
            assign phys_addr = mem_addr;
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        discard_next = discard_reg;
        latch_req    = 1'b0;
        capture      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    latch_req  = 1'b1;
                    state_next = bus.data_addr_ok ? S_DATA : S_ADDR;
                end
            end
            S_ADDR: begin
                if (flush | mem_except) begin
                    discard_next = 1'b1;
                end
                // data_ok cannot arrive with addr_ok, so it is not examined here.
                if (bus.data_addr_ok) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (flush | mem_except) begin
                    discard_next = 1'b1;
                end
                if (bus.data_data_ok) begin
                    discard_next = 1'b0;
                    if (kill) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_DONE;
                        capture    = ~wr_reg;
                    end
                end
            end
            S_DONE: begin
                if (flush | ~stall_others) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            discard_reg   <= 1'b0;
            rdata_buf_reg <= 32'h0;
            wr_reg        <= 1'b0;
            size_reg      <= 2'd0;
            addr_reg      <= 32'h0;
            wstrb_reg     <= 4'h0;
            wdata_reg     <= 32'h0;
        end else begin
            state_reg   <= state_next;
            discard_reg <= discard_next;
            if (capture) begin
                rdata_buf_reg <= bus.data_rdata;
            end
            if (latch_req) begin
                wr_reg    <= mem_wen;
                size_reg  <= mem_size;
                addr_reg  <= phys_addr;
                wstrb_reg <= mem_sel;
                wdata_reg <= mem_wdata;
            end
        end
    end

    // Byte lanes come straight from MEM while idle so the request can go out in the same cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wstrb_out[gi]        = use_reg ? wstrb_reg[gi] : mem_sel[gi];
            assign wdata_out[gi*8 +: 8] = use_reg ? wdata_reg[gi*8 +: 8] : mem_wdata[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_size  = 2'd0;
        bus.data_addr  = 32'h0;
        bus.data_wstrb = 4'h0;
        bus.data_wdata = 32'h0;
        mem_stall      = 1'b0;
        mem_rdata      = 32'h0;
        if (!rst) begin
            bus.data_req   = ((state_reg == S_IDLE) & start) | (state_reg == S_ADDR);
            bus.data_wr    = use_reg ? wr_reg : mem_wen;
            bus.data_size  = use_reg ? size_reg : mem_size;
            bus.data_addr  = use_reg ? addr_reg : phys_addr;
            bus.data_wstrb = wstrb_out;
            bus.data_wdata = wdata_out;
            // A killed transaction still blocks a newly arriving access until it drains.
            mem_stall      = ((state_reg == S_IDLE) & start)
                           | (in_flight & (~discard_reg | mem_en));
            mem_rdata      = rdata_buf_reg;
        end
    end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Bench for data_sram_bridge: table of single transactions against a small bus responder,
// plus hand sequences for stall_others, flush-drain, exceptions and reset.
module tb_data_sram_bridge;

    logic        clk;
    logic        rst;
    logic        mem_en;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_except;
    logic        flush;
    logic        stall_others;
    logic [31:0] mem_rdata;
    logic        mem_stall;

    data_sram_if bus ();

    data_sram_bridge #(.KSEG_MAP(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_en       (mem_en),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_sel      (mem_sel),
        .mem_wdata    (mem_wdata),
        .mem_size     (mem_size),
        .mem_except   (mem_except),
        .flush        (flush),
        .stall_others (stall_others),
        .bus          (bus),
        .mem_rdata    (mem_rdata),
        .mem_stall    (mem_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [1:0]  size;
        int          addr_dly;
        int          data_dly;
        logic [31:0] bus_rdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
    } exp_t;

    vec_t  vecs [7];
    exp_t  sb [$];
    exp_t  e;
    exp_t  got;
    int    n_pass;
    int    n_total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rst          = 1'b0;
        mem_en       = 1'b0;
        mem_wen      = 1'b0;
        mem_addr     = 32'h0;
        mem_sel      = 4'h0;
        mem_wdata    = 32'h0;
        mem_size     = 2'd0;
        mem_except   = 1'b0;
        flush        = 1'b0;
        stall_others = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = $urandom;
    endtask

    task automatic ld(input logic [31:0] a);
        mem_en   = 1'b1;
        mem_wen  = 1'b0;
        mem_addr = a;
        mem_sel  = 4'hF;
        mem_size = 2'd2;
    endtask

    // Per-transaction bench state for the table runner.
    vec_t        v;
    int          phase;
    int          acnt;
    int          dcnt;
    int          reqs;
    int          stalls;
    int          cyc;
    bit          done;
    bit          unstable;
    logic [70:0] snap;
    logic [70:0] fields;
    int          bad_hold;
    int          bad_stall;

    initial begin
        n_pass  = 0;
        n_total = 0;
        //               wen   addr          sel    wdata         size ad dd bus_rdata     exp_addr      exp_rdata
        vecs[0] = '{1'b0, 32'h8000_0100, 4'hF, 32'h0,         2'd2, 0, 2, 32'hDEAD_BEEF, 32'h0000_0100, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 32'h8000_0102, 4'h4, 32'h00AB_0000, 2'd0, 3, 1, 32'hFFFF_0001, 32'h0000_0102, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 32'hA000_0206, 4'hC, 32'h0,         2'd1, 1, 1, 32'h1234_5678, 32'h0000_0206, 32'h1234_5678};
        vecs[3] = '{1'b0, 32'h1FC0_0010, 4'hF, 32'h0,         2'd2, 0, 1, 32'hCAFE_F00D, 32'h1FC0_0010, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 32'hBFFF_FFFC, 4'hF, 32'h0BAD_F00D, 2'd2, 2, 3, 32'hFFFF_0004, 32'h1FFF_FFFC, 32'hCAFE_F00D};
        vecs[5] = '{1'b0, 32'hC000_0000, 4'hF, 32'h0,         2'd2, 0, 1, 32'h55AA_33CC, 32'hC000_0000, 32'h55AA_33CC};
        vecs[6] = '{1'b0, 32'h7FFF_FFF0, 4'h3, 32'h0,         2'd1, 2, 2, 32'h0F0F_A5A5, 32'h7FFF_FFF0, 32'h0F0F_A5A5};

        // Reset: outputs forced low while rst is high, cleared state afterwards.
        clr();
        rst = 1'b1;
        ld(32'h8000_0000);
        repeat (3) tick();
        #1;
        chk("rst_req", {31'h0, bus.data_req}, 32'h0);
        chk("rst_stall", {31'h0, mem_stall}, 32'h0);
        tick();
        clr();
        #1;
        chk("post_rst_rdata", mem_rdata, 32'h0);
        chk("post_rst_req", {31'h0, bus.data_req}, 32'h0);

        // Table-driven transactions, back to back.
        for (int i = 0; i < 7; i++) begin
            v        = vecs[i];
            e.addr   = v.exp_addr;
            e.rdata  = v.exp_rdata;
            sb.push_back(e);
            phase    = 0;
            acnt     = 0;
            dcnt     = 0;
            reqs     = 0;
            stalls   = 0;
            cyc      = 0;
            done     = 1'b0;
            unstable = 1'b0;
            snap     = '0;
            while (!done && cyc < 40) begin
                tick();
                clr();
                mem_en    = 1'b1;
                mem_wen   = v.wen;
                mem_addr  = v.addr;
                mem_sel   = v.sel;
                mem_wdata = v.wdata;
                mem_size  = v.size;
                bus.data_addr_ok = (phase == 0) && (acnt == v.addr_dly);
                bus.data_data_ok = (phase == 1) && (dcnt == v.data_dly);
                if (bus.data_data_ok) bus.data_rdata = v.bus_rdata;
                #1;
                fields = {bus.data_wr, bus.data_size, bus.data_wstrb, bus.data_addr, bus.data_wdata};
                if (bus.data_req) begin
                    reqs++;
                    if (reqs == 1) begin
                        snap = fields;
                        chk($sformatf("v%0d_addr", i), bus.data_addr, sb[0].addr);
                        chk($sformatf("v%0d_ctrl", i), {25'h0, bus.data_wr, bus.data_size, bus.data_wstrb},
                            {25'h0, v.wen, v.size, v.sel});
                        chk($sformatf("v%0d_wdata", i), bus.data_wdata, v.wdata);
                    end else if (fields !== snap) begin
                        unstable = 1'b1;
                    end
                end
                if (mem_stall) begin
                    stalls++;
                end else begin
                    done = 1'b1;
                    got  = sb.pop_front();
                    chk($sformatf("v%0d_rdata", i), mem_rdata, got.rdata);
                end
                if (phase == 0) begin
                    if (bus.data_req) begin
                        if (bus.data_addr_ok) begin
                            phase = 1;
                            dcnt  = 1;
                        end else begin
                            acnt++;
                        end
                    end
                end else if (phase == 1) begin
                    if (bus.data_data_ok) phase = 2;
                    else dcnt++;
                end
                cyc++;
            end
            chk($sformatf("v%0d_done", i), {31'h0, done}, 32'h1);
            chk($sformatf("v%0d_nreq", i), reqs, v.addr_dly + 1);
            chk($sformatf("v%0d_nstall", i), stalls, v.addr_dly + v.data_dly + 1);
            chk($sformatf("v%0d_stable", i), {31'h0, unstable}, 32'h0);
            $display("txn %0d: %s addr=%h req_cycles=%0d stall_cycles=%0d mem_rdata=%h",
                     i, v.wen ? "store" : "load", v.addr, reqs, stalls, mem_rdata);
        end

        // Load finishing under stall_others: one request, DONE held, no re-issue.
        reqs      = 0;
        bad_hold  = 0;
        bad_stall = 0;
        for (int c = 0; c <= 8; c++) begin
            tick();
            clr();
            if (c <= 7) ld(32'h8000_0040);
            stall_others     = (c <= 6);
            bus.data_addr_ok = (c == 0);
            bus.data_data_ok = (c == 1);
            if (c == 1) bus.data_rdata = 32'h1111_2222;
            #1;
            if (bus.data_req) reqs++;
            if (c >= 2 && c <= 7) begin
                if (mem_rdata !== 32'h1111_2222) bad_hold++;
                if (mem_stall) bad_stall++;
            end
        end
        chk("so_nreq", reqs, 1);
        chk("so_hold", bad_hold, 0);
        chk("so_stall", bad_stall, 0);
        $display("txn stall_others: req_cycles=%0d mem_rdata=%h", reqs, mem_rdata);

        // Flush during DATA, then a new load must wait for the old data_ok to drain.
        tick(); clr(); ld(32'h8000_0080); bus.data_addr_ok = 1'b1; #1;
        chk("fl_c0_req", {31'h0, bus.data_req}, 32'h1);
        tick(); clr(); ld(32'h8000_0080); flush = 1'b1; #1;
        chk("fl_c1_stall", {31'h0, mem_stall}, 32'h1);
        tick(); clr(); ld(32'h8000_0090); #1;
        chk("fl_c2_req", {31'h0, bus.data_req}, 32'h0);
        chk("fl_c2_stall", {31'h0, mem_stall}, 32'h1);
        tick(); clr(); ld(32'h8000_0090); bus.data_data_ok = 1'b1; bus.data_rdata = 32'h9999_9999; #1;
        chk("fl_c3_req", {31'h0, bus.data_req}, 32'h0);
        chk("fl_c3_stall", {31'h0, mem_stall}, 32'h1);
        tick(); clr(); ld(32'h8000_0090); bus.data_addr_ok = 1'b1; #1;
        chk("fl_c4_rdata", mem_rdata, 32'h1111_2222);
        chk("fl_c4_req", {31'h0, bus.data_req}, 32'h1);
        chk("fl_c4_addr", bus.data_addr, 32'h0000_0090);
        chk("fl_c4_stall", {31'h0, mem_stall}, 32'h1);
        tick(); clr(); ld(32'h8000_0090); bus.data_data_ok = 1'b1; bus.data_rdata = 32'h7777_8888; #1;
        chk("fl_c5_stall", {31'h0, mem_stall}, 32'h1);
        tick(); clr(); ld(32'h8000_0090); #1;
        chk("fl_c6_stall", {31'h0, mem_stall}, 32'h0);
        chk("fl_c6_rdata", mem_rdata, 32'h7777_8888);
        $display("txn flush-drain: new load mem_rdata=%h", mem_rdata);

        // Exception (AdEL) or flush in IDLE: nothing reaches the bus, no stall.
        for (int c = 0; c < 4; c++) begin
            tick(); clr(); ld(32'h8000_0002);
            if (c < 3) mem_except = 1'b1;
            else flush = 1'b1;
            #1;
            chk($sformatf("exc%0d_req", c), {31'h0, bus.data_req}, 32'h0);
            chk($sformatf("exc%0d_stall", c), {31'h0, mem_stall}, 32'h0);
        end
        $display("txn except/flush idle: req=%0d stall=%0d", bus.data_req, mem_stall);

        // Reset in the middle of DATA, then a clean load.
        tick(); clr(); ld(32'h8000_0010); bus.data_addr_ok = 1'b1; #1;
        tick(); clr(); ld(32'h8000_0010); rst = 1'b1; #1;
        chk("mrst_req", {31'h0, bus.data_req}, 32'h0);
        chk("mrst_stall", {31'h0, mem_stall}, 32'h0);
        chk("mrst_rdata", mem_rdata, 32'h0);
        tick(); clr(); #1;
        chk("mrst_after_req", {31'h0, bus.data_req}, 32'h0);
        chk("mrst_after_stall", {31'h0, mem_stall}, 32'h0);
        chk("mrst_after_rdata", mem_rdata, 32'h0);
        tick(); clr(); ld(32'h8000_0020); bus.data_addr_ok = 1'b1; #1;
        chk("mrst_new_addr", bus.data_addr, 32'h0000_0020);
        tick(); clr(); ld(32'h8000_0020); bus.data_data_ok = 1'b1; bus.data_rdata = 32'h5A5A_5A5A; #1;
        chk("mrst_new_stall", {31'h0, mem_stall}, 32'h1);
        tick(); clr(); ld(32'h8000_0020); #1;
        chk("mrst_new_done", {31'h0, mem_stall}, 32'h0);
        chk("mrst_new_rdata", mem_rdata, 32'h5A5A_5A5A);
        $display("txn reset-mid-data: reload mem_rdata=%h", mem_rdata);

        tick(); clr();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
